// File: rtl/naval_pkg.sv
// Shared types and constants for the battleship referee.
package naval_pkg;

    localparam int unsigned NAV_COORD_W = 3;
    localparam int unsigned NAV_CELLS   = 2 ** NAV_COORD_W;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        P1_TURN = 2'b01,
        P2_TURN = 2'b10,
        DONE    = 2'b11
    } state_e;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

endpackage

// File: rtl/fleet_board.sv
// One defended board: constant fleet mask plus the mask of ship cells already hit.
module fleet_board
    import naval_pkg::*;
#(
    parameter int unsigned         COORD_W = NAV_COORD_W,
    parameter logic [2**COORD_W-1:0] FLEET = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               fire,
    input  logic [COORD_W-1:0] coord,
    output logic               hit,
    output logic               all_sunk
);

    localparam int unsigned CELLS = 2 ** COORD_W;

    if (FLEET == '0) begin : g_bad_fleet
        $error("fleet_board: FLEET mask must not be zero");
    end

    logic [CELLS-1:0] r_hit_mask;
    logic [CELLS-1:0] w_onehot;
    logic [CELLS-1:0] w_mask_nxt;

    always_comb begin
        w_onehot        = '0;
        w_onehot[coord] = 1'b1;
        hit             = fire & FLEET[coord] & ~r_hit_mask[coord];
        // Only ship cells enter the mask so it can be compared against FLEET directly.
        w_mask_nxt      = fire ? (r_hit_mask | (w_onehot & FLEET)) : r_hit_mask;
        all_sunk        = (w_mask_nxt == FLEET);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_mask <= '0;
        end else if (clear) begin
            r_hit_mask <= '0;
        end else begin
            r_hit_mask <= w_mask_nxt;
        end
    end

endmodule

// File: rtl/naval_referee.sv
// Turn-based battleship referee: alternates shots, scores new hits, declares winner or draw.
module naval_referee
    import naval_pkg::*;
#(
    parameter int unsigned           COORD_W    = NAV_COORD_W,
    parameter logic [2**COORD_W-1:0] FLEET1     = 8'h06,
    parameter logic [2**COORD_W-1:0] FLEET2     = 8'h30,
    parameter int unsigned           TURN_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] p1_shot,
    input  logic               p1_valid,
    output logic               p1_ready,
    input  logic [COORD_W-1:0] p2_shot,
    input  logic               p2_valid,
    output logic               p2_ready,
    output logic               result_valid,
    output logic               result_hit,
    output logic               result_player,
    output logic [3:0]         score1,
    output logic [3:0]         score2,
    output logic               game_over,
    output logic [1:0]         winner
);

    if (TURN_LIMIT < 2 || TURN_LIMIT > 255) begin : g_bad_limit
        $error("naval_referee: TURN_LIMIT must be in 2..255");
    end

    state_e     r_state, w_state_nxt;
    logic [7:0] r_shots, w_shots_nxt;
    logic [3:0] r_score1, w_score1_nxt;
    logic [3:0] r_score2, w_score2_nxt;
    logic       r_res_valid, w_res_valid_nxt;
    logic       r_res_hit, w_res_hit_nxt;
    logic       r_res_player, w_res_player_nxt;
    logic       r_game_over, w_game_over_nxt;
    logic [1:0] r_winner, w_winner_nxt;

    logic w_p1_acc, w_p2_acc;
    logic w_p1_hit, w_p2_hit;
    logic w_b1_sunk, w_b2_sunk;
    logic w_limit;

    assign p1_ready = (r_state == P1_TURN);
    assign p2_ready = (r_state == P2_TURN);

    // start outranks any shot presented in the same cycle.
    assign w_p1_acc = p1_valid & p1_ready & ~start;
    assign w_p2_acc = p2_valid & p2_ready & ~start;
    assign w_limit  = ((r_shots + 8'd1) == 8'(TURN_LIMIT));

    // Board 1 holds FLEET1 and is shot at by player 2; board 2 the reverse.
    fleet_board #(
        .COORD_W (COORD_W),
        .FLEET   (FLEET1)
    ) u_board1 (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .fire     (w_p2_acc),
        .coord    (p2_shot),
        .hit      (w_p2_hit),
        .all_sunk (w_b1_sunk)
    );

    fleet_board #(
        .COORD_W (COORD_W),
        .FLEET   (FLEET2)
    ) u_board2 (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .fire     (w_p1_acc),
        .coord    (p1_shot),
        .hit      (w_p1_hit),
        .all_sunk (w_b2_sunk)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_shots_nxt      = r_shots;
        w_score1_nxt     = r_score1;
        w_score2_nxt     = r_score2;
        w_res_valid_nxt  = 1'b0;
        w_res_hit_nxt    = r_res_hit;
        w_res_player_nxt = r_res_player;
        w_game_over_nxt  = r_game_over;
        w_winner_nxt     = r_winner;

        if (start) begin
            w_state_nxt      = P1_TURN;
            w_shots_nxt      = '0;
            w_score1_nxt     = '0;
            w_score2_nxt     = '0;
            w_res_hit_nxt    = 1'b0;
            w_res_player_nxt = 1'b0;
            w_game_over_nxt  = 1'b0;
            w_winner_nxt     = W_NONE;
        end else if (w_p1_acc || w_p2_acc) begin
            w_shots_nxt      = r_shots + 8'd1;
            w_res_valid_nxt  = 1'b1;
            w_res_hit_nxt    = w_p1_acc ? w_p1_hit : w_p2_hit;
            w_res_player_nxt = w_p2_acc;
            if (w_p1_acc && w_p1_hit) w_score1_nxt = r_score1 + 4'd1;
            if (w_p2_acc && w_p2_hit) w_score2_nxt = r_score2 + 4'd1;

            if ((w_p1_acc && w_b2_sunk) || (w_p2_acc && w_b1_sunk)) begin
                w_state_nxt     = DONE;
                w_game_over_nxt = 1'b1;
                w_winner_nxt    = w_p1_acc ? W_P1 : W_P2;
            end else if (w_limit) begin
                w_state_nxt     = DONE;
                w_game_over_nxt = 1'b1;
                w_winner_nxt    = W_DRAW;
            end else begin
                w_state_nxt = w_p1_acc ? P2_TURN : P1_TURN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shots      <= '0;
            r_score1     <= '0;
            r_score2     <= '0;
            r_res_valid  <= 1'b0;
            r_res_hit    <= 1'b0;
            r_res_player <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= W_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_shots      <= w_shots_nxt;
            r_score1     <= w_score1_nxt;
            r_score2     <= w_score2_nxt;
            r_res_valid  <= w_res_valid_nxt;
            r_res_hit    <= w_res_hit_nxt;
            r_res_player <= w_res_player_nxt;
            r_game_over  <= w_game_over_nxt;
            r_winner     <= w_winner_nxt;
        end
    end

    assign result_valid  = r_res_valid;
    assign result_hit    = r_res_hit;
    assign result_player = r_res_player;
    assign score1        = r_score1;
    assign score2        = r_score2;
    assign game_over     = r_game_over;
    assign winner        = r_winner;

endmodule

// File: tb/tb_naval_referee.sv
// Directed bench: one referee with default limit (win path), one with TURN_LIMIT=4 (draw path).
module tb_naval_referee;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_start, a_p1_valid, a_p2_valid, a_p1_ready, a_p2_ready;
    logic [2:0] a_p1_shot, a_p2_shot;
    logic       a_rv, a_hit, a_pl, a_over;
    logic [3:0] a_s1, a_s2;
    logic [1:0] a_win;

    logic       b_start, b_p1_valid, b_p2_valid, b_p1_ready, b_p2_ready;
    logic [2:0] b_p1_shot, b_p2_shot;
    logic       b_rv, b_hit, b_pl, b_over;
    logic [3:0] b_s1, b_s2;
    logic [1:0] b_win;

    int total = 0;
    int bad   = 0;

    naval_referee u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .start         (a_start),
        .p1_shot       (a_p1_shot),
        .p1_valid      (a_p1_valid),
        .p1_ready      (a_p1_ready),
        .p2_shot       (a_p2_shot),
        .p2_valid      (a_p2_valid),
        .p2_ready      (a_p2_ready),
        .result_valid  (a_rv),
        .result_hit    (a_hit),
        .result_player (a_pl),
        .score1        (a_s1),
        .score2        (a_s2),
        .game_over     (a_over),
        .winner        (a_win)
    );

    naval_referee #(
        .TURN_LIMIT (4)
    ) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .start         (b_start),
        .p1_shot       (b_p1_shot),
        .p1_valid      (b_p1_valid),
        .p1_ready      (b_p1_ready),
        .p2_shot       (b_p2_shot),
        .p2_valid      (b_p2_valid),
        .p2_ready      (b_p2_ready),
        .result_valid  (b_rv),
        .result_hit    (b_hit),
        .result_player (b_pl),
        .score1        (b_s1),
        .score2        (b_s2),
        .game_over     (b_over),
        .winner        (b_win)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic fire_a(input logic pl, input logic [2:0] c);
        int n = 0;
        if (pl) begin a_p2_shot = c; a_p2_valid = 1'b1; end
        else begin a_p1_shot = c; a_p1_valid = 1'b1; end
        while (((pl ? a_p2_ready : a_p1_ready) !== 1'b1) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_wait", 8'(n < 10), 8'd1);
        @(negedge clk);
        a_p1_valid = 1'b0;
        a_p2_valid = 1'b0;
    endtask

    task automatic fire_b(input logic pl, input logic [2:0] c);
        int n = 0;
        if (pl) begin b_p2_shot = c; b_p2_valid = 1'b1; end
        else begin b_p1_shot = c; b_p1_valid = 1'b1; end
        while (((pl ? b_p2_ready : b_p1_ready) !== 1'b1) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b_ready_wait", 8'(n < 10), 8'd1);
        @(negedge clk);
        b_p1_valid = 1'b0;
        b_p2_valid = 1'b0;
    endtask

    task automatic res_a(input string tag, input logic hit, input logic pl,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic over, input logic [1:0] win);
        chk({tag, "_rv"},   8'(a_rv),   8'd1);
        chk({tag, "_hit"},  8'(a_hit),  8'(hit));
        chk({tag, "_pl"},   8'(a_pl),   8'(pl));
        chk({tag, "_s1"},   8'(a_s1),   8'(s1));
        chk({tag, "_s2"},   8'(a_s2),   8'(s2));
        chk({tag, "_over"}, 8'(a_over), 8'(over));
        chk({tag, "_win"},  8'(a_win),  8'(win));
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_p1_valid = 1'b0; a_p2_valid = 1'b0; a_p1_shot = '0; a_p2_shot = '0;
        b_start = 1'b0; b_p1_valid = 1'b0; b_p2_valid = 1'b0; b_p1_shot = '0; b_p2_shot = '0;

        // Reset state, with a p1 shot presented that must be ignored.
        @(negedge clk);
        a_p1_valid = 1'b1; a_p1_shot = 3'd4;
        @(negedge clk);
        chk("rst_rv",    8'(a_rv),       8'd0);
        chk("rst_s1",    8'(a_s1),       8'd0);
        chk("rst_s2",    8'(a_s2),       8'd0);
        chk("rst_over",  8'(a_over),     8'd0);
        chk("rst_win",   8'(a_win),      8'd0);
        chk("rst_p1rdy", 8'(a_p1_ready), 8'd0);
        chk("rst_p2rdy", 8'(a_p2_ready), 8'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_rv",    8'(a_rv),       8'd0);
        chk("idle_p1rdy", 8'(a_p1_ready), 8'd0);
        a_p1_valid = 1'b0;

        // Game A: p1 wins on its third shot.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("start_p1rdy", 8'(a_p1_ready), 8'd1);
        chk("start_rv",    8'(a_rv),       8'd0);

        fire_a(1'b0, 3'd4);
        res_a("a1", 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);
        chk("a1_p2rdy", 8'(a_p2_ready), 8'd1);
        chk("a1_p1rdy", 8'(a_p1_ready), 8'd0);
        @(negedge clk);
        chk("a1_rv_drop", 8'(a_rv), 8'd0);

        fire_a(1'b1, 3'd0);
        res_a("a2", 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 2'b00);
        fire_a(1'b0, 3'd4);
        res_a("a3_repeat", 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);
        fire_a(1'b1, 3'd7);
        res_a("a4", 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 2'b00);
        fire_a(1'b0, 3'd5);
        res_a("a5_win", 1'b1, 1'b0, 4'd2, 4'd0, 1'b1, 2'b01);
        chk("done_p1rdy", 8'(a_p1_ready), 8'd0);
        chk("done_p2rdy", 8'(a_p2_ready), 8'd0);

        a_p1_valid = 1'b1; a_p1_shot = 3'd4;
        a_p2_valid = 1'b1; a_p2_shot = 3'd1;
        @(negedge clk);
        @(negedge clk);
        chk("done_ign_rv",  8'(a_rv),  8'd0);
        chk("done_ign_s1",  8'(a_s1),  8'd2);
        chk("done_ign_s2",  8'(a_s2),  8'd0);
        chk("done_ign_win", 8'(a_win), 8'd1);
        a_p1_valid = 1'b0; a_p2_valid = 1'b0;

        // Restart, then a start colliding with a p1 shot mid-game.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("restart_s1",   8'(a_s1),   8'd0);
        chk("restart_over", 8'(a_over), 8'd0);
        chk("restart_win",  8'(a_win),  8'd0);
        fire_a(1'b0, 3'd4);
        res_a("m1", 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);
        fire_a(1'b1, 3'd0);
        res_a("m2", 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 2'b00);
        a_start = 1'b1; a_p1_valid = 1'b1; a_p1_shot = 3'd4;
        @(negedge clk);
        a_start = 1'b0; a_p1_valid = 1'b0;
        chk("coll_rv",    8'(a_rv),       8'd0);
        chk("coll_s1",    8'(a_s1),       8'd0);
        chk("coll_win",   8'(a_win),      8'd0);
        chk("coll_p1rdy", 8'(a_p1_ready), 8'd1);
        fire_a(1'b0, 3'd4);
        res_a("coll_rehit", 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);

        // Game B (TURN_LIMIT=4): out-of-turn p2 shot ignored, then four misses draw.
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_p2_valid = 1'b1; b_p2_shot = 3'd1;
        @(negedge clk);
        b_p2_valid = 1'b0;
        chk("b_oot_rv",    8'(b_rv),       8'd0);
        chk("b_oot_p1rdy", 8'(b_p1_ready), 8'd1);
        fire_b(1'b0, 3'd0);
        fire_b(1'b1, 3'd0);
        fire_b(1'b0, 3'd1);
        chk("b3_rv",   8'(b_rv),   8'd1);
        chk("b3_over", 8'(b_over), 8'd0);
        fire_b(1'b1, 3'd7);
        chk("b4_rv",   8'(b_rv),   8'd1);
        chk("b4_hit",  8'(b_hit),  8'd0);
        chk("b4_pl",   8'(b_pl),   8'd1);
        chk("b4_over", 8'(b_over), 8'd1);
        chk("b4_win",  8'(b_win),  8'd3);
        chk("b4_s1",   8'(b_s1),   8'd0);
        chk("b4_s2",   8'(b_s2),   8'd0);

        // Mid-game reset on A returns everything to idle values.
        fire_a(1'b1, 3'd1);
        rst = 1'b1;
        #1;
        chk("arst_s2",    8'(a_s2),       8'd0);
        chk("arst_rv",    8'(a_rv),       8'd0);
        chk("arst_p1rdy", 8'(a_p1_ready), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
